// File: rtl/dino_game_ctrl.sv
// Game sequencer for the dino obstacle game: tick generator, game FSM,
// lives tracking, datapath run/restart control and end-of-round flash strobe.
module dino_game_ctrl #(
  parameter int unsigned TICK_PERIOD = 500,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned READY_TICKS = 4,
  parameter int unsigned HIT_TICKS   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_pause,
  input  logic       collision_detected,
  input  logic       game_cleared,
  output logic       run_game,
  output logic       restart,
  output logic [1:0] lives_left,
  output logic [2:0] state,
  output logic       flash
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    HIT   = 3'd4,
    CLEAR = 3'd5,
    OVER  = 3'd6,
    BAD   = 3'd7
  } st_e;

  st_e         cur_st, nxt_st;
  logic [23:0] tick_cnt;
  logic        tick;
  logic [3:0]  rdy_cnt, hit_cnt;
  logic        run_d, restart_d, flash_d;
  logic [1:0]  lives_d;

  assign tick = (tick_cnt == 24'(TICK_PERIOD - 1));

  // Outputs are registered from the next-state decode, so they change on the
  // same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt   <= '0;
      cur_st     <= IDLE;
      rdy_cnt    <= '0;
      hit_cnt    <= '0;
      run_game   <= 1'b0;
      restart    <= 1'b0;
      lives_left <= '0;
      flash      <= 1'b0;
    end else begin
      tick_cnt   <= tick ? '0 : tick_cnt + 24'd1;
      cur_st     <= nxt_st;
      rdy_cnt    <= (nxt_st != READY || cur_st != READY) ? '0 :
                    (tick ? rdy_cnt + 4'd1 : rdy_cnt);
      hit_cnt    <= (nxt_st != HIT || cur_st != HIT) ? '0 :
                    (tick ? hit_cnt + 4'd1 : hit_cnt);
      run_game   <= run_d;
      restart    <= restart_d;
      lives_left <= lives_d;
      flash      <= flash_d;
    end
  end

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      IDLE:  if (key_start) nxt_st = READY;
      READY: if (tick && rdy_cnt == 4'(READY_TICKS - 1)) nxt_st = RUN;
      RUN: begin
        if (collision_detected)  nxt_st = HIT;
        else if (game_cleared)   nxt_st = CLEAR;
        else if (key_pause)      nxt_st = PAUSE;
      end
      PAUSE: begin
        if (key_start)           nxt_st = IDLE;
        else if (key_pause)      nxt_st = RUN;
      end
      HIT: if (tick && hit_cnt == 4'(HIT_TICKS - 1))
             nxt_st = (lives_left == 2'd0) ? OVER : READY;
      CLEAR, OVER: if (key_start) nxt_st = READY;
      default: nxt_st = IDLE;
    endcase
  end

  always_comb begin
    run_d     = (nxt_st == RUN);
    restart_d = (nxt_st == READY) && (cur_st != READY);
    lives_d   = lives_left;
    if (restart_d && cur_st != HIT)
      lives_d = 2'(LIVES);
    else if (nxt_st == HIT && cur_st == RUN)
      lives_d = (lives_left == 2'd0) ? 2'd0 : lives_left - 2'd1;
    flash_d = flash;
    if (nxt_st == IDLE || nxt_st == READY || nxt_st == RUN ||
        nxt_st == PAUSE || nxt_st == BAD)
      flash_d = 1'b0;
    else if (tick && (cur_st == HIT || cur_st == CLEAR || cur_st == OVER))
      flash_d = ~flash;
  end

  assign state = cur_st;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Randomized and directed bench for dino_game_ctrl, checked every cycle
// against an integer-level behavioural model of the game rules.
module tb_dino_game_ctrl;

  localparam int TP = 5;
  localparam int NL = 3;
  localparam int RT = 4;
  localparam int HT = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_start = 1'b0;
  logic       key_pause = 1'b0;
  logic       collision_detected = 1'b0;
  logic       game_cleared = 1'b0;
  logic       run_game, restart, flash;
  logic [1:0] lives_left;
  logic [2:0] state;

  dino_game_ctrl #(
    .TICK_PERIOD(TP),
    .LIVES(NL),
    .READY_TICKS(RT),
    .HIT_TICKS(HT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_start(key_start),
    .key_pause(key_pause),
    .collision_detected(collision_detected),
    .game_cleared(game_cleared),
    .run_game(run_game),
    .restart(restart),
    .lives_left(lives_left),
    .state(state),
    .flash(flash)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: game state as an int, ticks counted since entering the state,
  // clock phase within the game tick.
  int m_state = 0, m_lives = 0, m_ticks = 0, m_phase = 0;
  int m_run = 0, m_restart = 0, m_flash = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int s, input int p, input int c, input int g, input int r);
    int tk, prev, nxt;
    if (r != 0) begin
      m_state = 0; m_lives = 0; m_ticks = 0; m_phase = 0;
      m_run = 0; m_restart = 0; m_flash = 0;
      return;
    end
    tk = (m_phase == TP - 1);
    m_phase = (m_phase + 1) % TP;
    prev = m_state;
    nxt = prev;
    case (prev)
      0: if (s != 0) nxt = 1;
      1: if (tk != 0) begin
           m_ticks++;
           if (m_ticks == RT) nxt = 2;
         end
      2: if (c != 0) nxt = 4; else if (g != 0) nxt = 5; else if (p != 0) nxt = 3;
      3: if (s != 0) nxt = 0; else if (p != 0) nxt = 2;
      4: if (tk != 0) begin
           m_ticks++;
           if (m_ticks == HT) nxt = (m_lives == 0) ? 6 : 1;
         end
      5, 6: if (s != 0) nxt = 1;
      default: nxt = 0;
    endcase
    m_restart = (nxt == 1 && prev != 1);
    if (m_restart != 0 && prev != 4) m_lives = NL;
    if (nxt == 4 && prev == 2) m_lives = (m_lives > 0) ? m_lives - 1 : 0;
    if (nxt != prev) m_ticks = 0;
    if (nxt < 4) m_flash = 0;
    else if (tk != 0 && prev >= 4) m_flash = 1 - m_flash;
    m_run = (nxt == 2);
    m_state = nxt;
  endtask

  task automatic step(input int s, input int p, input int c, input int g, input int r);
    key_start = 1'(s);
    key_pause = 1'(p);
    collision_detected = 1'(c);
    game_cleared = 1'(g);
    rst = 1'(r);
    @(posedge clk);
    model_step(s, p, c, g, r);
    #1;
    check_val("state", int'(state), m_state);
    check_val("run_game", int'(run_game), m_run);
    check_val("restart", int'(restart), m_restart);
    check_val("lives_left", int'(lives_left), m_lives);
    check_val("flash", int'(flash), m_flash);
  endtask

  task automatic run_until(input int target, input int budget);
    int n = 0;
    while (m_state != target && n < budget) begin
      step(0, 0, 0, 0, 0);
      n++;
    end
    check_val("wait_state", m_state, target);
  endtask

  task automatic wait_leave(input int st, input int budget);
    int n = 0;
    while (m_state == st && n < budget) begin
      step(0, 0, 0, 0, 0);
      n++;
    end
    check_val("wait_leave", int'(m_state != st), 1);
  endtask

  initial begin
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check_val("reset_lives", int'(lives_left), 0);
    step(0, 0, 0, 0, 0);

    // Start, countdown, run.
    step(1, 0, 0, 0, 0);
    check_val("start_state", int'(state), 1);
    check_val("start_lives", int'(lives_left), 3);
    run_until(2, 200);

    // Simultaneous collision and clear: collision wins.
    step(0, 0, 1, 1, 0);
    check_val("hit_state", int'(state), 4);
    run_until(1, 200);
    run_until(2, 200);

    // Two more hits lead to game over.
    for (int i = 0; i < 2; i++) begin
      run_until(2, 200);
      step(0, 0, 1, 0, 0);
      wait_leave(4, 200);
    end
    check_val("over_state", int'(state), 6);
    for (int i = 0; i < 3 * TP; i++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check_val("reload_lives", int'(lives_left), 3);

    // Pause, resume, abort.
    run_until(2, 200);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check_val("abort_state", int'(state), 0);

    // Cleared round ignores later collisions.
    step(1, 0, 0, 0, 0);
    run_until(2, 200);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4 * TP; i++) step(0, 0, 1, 0, 0);
    check_val("clear_hold", int'(state), 5);

    // Reset mid-run with the tick counter mid-count.
    step(1, 0, 0, 0, 0);
    run_until(2, 200);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    run_until(2, 200);

    // Randomized play.
    for (int i = 0; i < 4000; i++) begin
      step(int'($urandom_range(0, 14) == 0), int'($urandom_range(0, 24) == 0),
           int'($urandom_range(0, 29) == 0), int'($urandom_range(0, 39) == 0),
           int'($urandom_range(0, 599) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dino_game_ctrl.md
# dino_game_ctrl

Top-level sequencer for the dino obstacle game. It owns the game state machine (idle, get-ready countdown, run, pause, hit, cleared, game over) and drives the obstacle/dino datapath through `run_game` and a one-cycle `restart` pulse. It consumes the datapath's `collision_detected` and `game_cleared` flags, tracks remaining lives, and produces a flash strobe for end-of-round display effects. It sits between the key triggers and the game datapath.

## Interface
- `TICK_PERIOD`, default 500: clk cycles per game tick; legal range 2..2^24-1.
- `LIVES`, default 3: lives loaded at game start; legal range 1..3.
- `READY_TICKS`, default 4: ticks spent in READY before RUN; legal range 1..15.
- `HIT_TICKS`, default 6: ticks spent in HIT before the next action; legal range 1..15.

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `key_start` in 1: start/restart request, a one-cycle pulse that is already debounced.
- `key_pause` in 1: pause toggle, a one-cycle pulse that is already debounced.
- `collision_detected` in 1: latched collision flag from the datapath.
- `game_cleared` in 1: latched all-obstacles-passed flag from the datapath.
- `run_game` out 1: datapath run enable.
- `restart` out 1: one-cycle pulse that clears the datapath sequence and flags.
- `lives_left` out 2: remaining lives.
- `state` out 3: current state code.
- `flash` out 1: display blink strobe.

## Operation
- Tick generator:
  - Free-running counter 0..TICK_PERIOD-1.
  - `tick` is high for one cycle when the count equals TICK_PERIOD-1; the counter then wraps to 0.
  - The counter runs in all states and is cleared only by `rst`.
- State codes: IDLE=0, READY=1, RUN=2, PAUSE=3, HIT=4, CLEAR=5, OVER=6. Code 7 is illegal and recovers to IDLE on the next cycle.
- IDLE:
  - `key_start` → READY; load `lives_left`=LIVES; assert `restart`; clear the ready counter.
- READY:
  - The ready counter increments on each `tick`.
  - When the count reaches READY_TICKS → RUN.
  - `key_start` is ignored.
- RUN: `run_game`=1. Transition priority, evaluated each cycle:
  1. `collision_detected` → HIT.
  2. `game_cleared` → CLEAR.
  3. `key_pause` → PAUSE.
- PAUSE:
  - `key_pause` → RUN.
  - `key_start` → IDLE (abort the game; `lives_left` is held).
  - If both pulse in the same cycle, `key_start` wins.
- HIT:
  - On entry, `lives_left` decrements by 1 (saturating at 0).
  - The hit counter counts `tick`s. At HIT_TICKS:
    - `lives_left`==0 → OVER.
    - Otherwise → READY, with `restart` asserted and the ready counter cleared.
- CLEAR and OVER:
  - `key_start` → READY; reload LIVES; assert `restart`.
- `flash`:
  - Toggles on every `tick` while in HIT, CLEAR or OVER.
  - Forced to 0 on any transition into IDLE, READY, RUN or PAUSE.
- `restart` is only ever asserted in the cycle of a transition into READY.
- `collision_detected` and `game_cleared` are ignored outside RUN. The datapath clears both flags after `restart`, so stale flags never leak into RUN, because at least READY_TICKS ticks pass before RUN.

## Timing
- Reset values: state=IDLE, `run_game`=0, `restart`=0, `lives_left`=0, `flash`=0, tick/ready/hit counters=0.
- All outputs are registered.
- An input sampled high at edge N changes `state`, and all outputs decoded from it, at edge N.
- `run_game` is high exactly during cycles where state==RUN; there is no combinational path from any input to any output.
- Latency figures:
  - Collision to `run_game` low: 1 cycle.
  - `key_start` in IDLE to `restart` high: 1 cycle, pulse width exactly 1 cycle.
  - Minimum READY→RUN: (READY_TICKS-1)·TICK_PERIOD+1 cycles, depending on tick phase.
- `rst` asserted mid-game: next edge returns everything to reset values; no `restart` pulse is produced by reset itself.
- A `tick` coinciding with a state entry is not counted in the new state.

## Test plan
- Reset, then `key_start` → `restart` is a 1-cycle pulse, `lives_left`=3, state=1; after 4 ticks state=2 and `run_game`=1.
- In RUN, pulse `collision_detected` and `game_cleared` in the same cycle → next cycle state=4, `run_game`=0, `lives_left`=2; after 6 ticks state=1 with `restart` pulsed.
- Three collisions in succession → after the third HIT, state=6, `lives_left`=0, `flash` toggling each tick; `key_start` → state=1, `lives_left`=3.
- In RUN, `key_pause` → state=3 and `run_game`=0; `key_pause` again → state=2; pulse `key_pause` and `key_start` together while paused → state=0.
- In RUN, assert `game_cleared` → state=5, `flash` toggles each tick; `collision_detected` asserted afterwards is ignored (state stays 5).
- Assert `rst` for 1 cycle while in RUN with the tick counter mid-count → all outputs return to reset values and the tick counter restarts from 0.
